// File: rtl/motor_current_guard.sv
// Overcurrent guard for a dual H-bridge drive: gates commands,
// inserts dead time on reversal, trips to cooldown, locks out.
module motor_current_guard #(
    parameter logic [11:0] THRESHOLD = 12'd2048,
    parameter int SAMPLE_DIV = 100000,
    parameter int TRIP_COUNT = 4,
    parameter int COOLDOWN_CYCLES = 100000000,
    parameter int DEADTIME_CYCLES = 1000000,
    parameter int MAX_RETRIES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  in_cmd,
    input  logic [11:0] current_value,
    output logic [3:0]  IN,
    output logic        fault,
    output logic        lockout,
    output logic [1:0]  retry_count,
    output logic [1:0]  state
);

    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int OW = $clog2(TRIP_COUNT + 1);
    localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int DW = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [OW-1:0] TRIP_LEVEL  = OW'(TRIP_COUNT);
    localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [DW-1:0] DEAD_LAST   = DW'(DEADTIME_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DEAD = 2'd1,
        COOL = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    in_q, in_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [SW-1:0] smp_cnt;
    logic [OW-1:0] over_cnt, over_d;
    logic [CW-1:0] cool_cnt, cool_d;
    logic [DW-1:0] dead_cnt, dead_d;
    logic [1:0]    retry_q, retry_d;
    logic          strobe;
    logic          over;
    logic          active;
    logic          trip;
    logic          reversal;

    // Sample divider free-runs regardless of state
    always_ff @(posedge clk) begin
        if (reset) begin
            smp_cnt <= '0;
        end else if (smp_cnt == SAMPLE_LAST) begin
            smp_cnt <= '0;
        end else begin
            smp_cnt <= smp_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            in_q     <= '0;
            cmd_q    <= '0;
            over_cnt <= '0;
            cool_cnt <= '0;
            dead_cnt <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            in_q     <= in_d;
            cmd_q    <= cmd_d;
            over_cnt <= over_d;
            cool_cnt <= cool_d;
            dead_cnt <= dead_d;
            retry_q  <= retry_d;
        end
    end

    always_comb begin
        strobe   = (smp_cnt == SAMPLE_LAST);
        over     = (current_value > THRESHOLD);
        active   = (state_q == RUN) || (state_q == DEAD);
        reversal = (in_cmd != cmd_q) && (cmd_q != 4'd0)
                   && (in_cmd != 4'd0);

        over_d = over_cnt;
        if (!active) begin
            over_d = '0;
        end else if (strobe) begin
            if (!over) begin
                over_d = '0;
            end else if (over_cnt != TRIP_LEVEL) begin
                over_d = over_cnt + OW'(1);
            end
        end
        trip = active && (over_d == TRIP_LEVEL);

        state_d = state_q;
        in_d    = in_q;
        cmd_d   = cmd_q;
        cool_d  = cool_cnt;
        dead_d  = dead_cnt;
        retry_d = retry_q;

        if (trip) begin
            in_d   = '0;
            over_d = '0;
            if (retry_q < RETRY_MAX) begin
                state_d = COOL;
                retry_d = retry_q + 2'd1;
                cool_d  = '0;
            end else begin
                state_d = LOCK;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (reversal) begin
                        state_d = DEAD;
                        in_d    = '0;
                        dead_d  = '0;
                    end else begin
                        in_d  = in_cmd;
                        cmd_d = in_cmd;
                    end
                end
                DEAD: begin
                    in_d = '0;
                    if (dead_cnt == DEAD_LAST) begin
                        state_d = RUN;
                        in_d    = in_cmd;
                        cmd_d   = in_cmd;
                    end else begin
                        dead_d = dead_cnt + DW'(1);
                    end
                end
                COOL: begin
                    in_d = '0;
                    if (cool_cnt == COOL_LAST) begin
                        state_d = RUN;
                        cmd_d   = '0;
                    end else begin
                        cool_d = cool_cnt + CW'(1);
                    end
                end
                LOCK: begin
                    in_d = '0;
                end
            endcase
        end
    end

    assign IN          = in_q;
    assign fault       = (state_q == COOL) || (state_q == LOCK);
    assign lockout     = (state_q == LOCK);
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_motor_current_guard.sv
// Directed bench for motor_current_guard with small parameters:
// DIV=4, TRIP=2, COOL=20, DEAD=8, RETRIES=1, THRESHOLD=100.
module tb_motor_current_guard;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_cmd;
    logic [11:0] current_value;
    logic [3:0]  IN;
    logic        fault;
    logic        lockout;
    logic [1:0]  retry_count;
    logic [1:0]  state;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int n      = 0;

    motor_current_guard #(
        .THRESHOLD(12'd100),
        .SAMPLE_DIV(4),
        .TRIP_COUNT(2),
        .COOLDOWN_CYCLES(20),
        .DEADTIME_CYCLES(8),
        .MAX_RETRIES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_cmd(in_cmd),
        .current_value(current_value),
        .IN(IN),
        .fault(fault),
        .lockout(lockout),
        .retry_count(retry_count),
        .state(state)
    );

    always #5 clk = ~clk;

    // Edges since reset release; a strobe edge follows when n%4==3
    always @(posedge clk) begin
        if (reset) n <= 0;
        else n <= n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic to_strobe();
        for (int i = 0; i < 8 && (n % 4) != 3; i++) @(negedge clk);
    endtask

    task automatic strobe_with(input logic [11:0] v);
        to_strobe();
        current_value = v;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b1;
        in_cmd = 4'b0000;
        current_value = 12'd0;
        step(3);
        chk("rst_in", IN, 4'b0000);
        chk("rst_state", state, 2'd0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_lock", lockout, 1'b0);
        chk("rst_retry", retry_count, 2'd0);

        reset = 1'b0;
        in_cmd = 4'b0101;
        current_value = 12'd50;
        step(1);
        chk("pass_first", IN, 4'b0101);
        step(10);
        chk("pass_hold", IN, 4'b0101);
        chk("pass_fault", fault, 1'b0);
        chk("pass_state", state, 2'd0);

        in_cmd = 4'b1010;
        step(1);
        chk("dead_enter_st", state, 2'd1);
        chk("dead_enter_in", IN, 4'b0000);
        step(7);
        chk("dead_last_st", state, 2'd1);
        chk("dead_last_in", IN, 4'b0000);
        step(1);
        chk("dead_exit_st", state, 2'd0);
        chk("dead_exit_in", IN, 4'b1010);

        in_cmd = 4'b0000;
        step(1);
        chk("zero_in", IN, 4'b0000);
        in_cmd = 4'b0101;
        step(1);
        chk("zero_rev_in", IN, 4'b0101);
        chk("zero_rev_st", state, 2'd0);

        current_value = 12'd100;
        step(13);
        chk("thr_eq_st", state, 2'd0);
        chk("thr_eq_fault", fault, 1'b0);

        strobe_with(12'd101);
        strobe_with(12'd50);
        strobe_with(12'd101);
        strobe_with(12'd50);
        chk("nonconsec_st", state, 2'd0);
        chk("nonconsec_retry", retry_count, 2'd0);

        strobe_with(12'd101);
        chk("trip1_pre_st", state, 2'd0);
        strobe_with(12'd101);
        current_value = 12'd50;
        chk("trip1_st", state, 2'd2);
        chk("trip1_fault", fault, 1'b1);
        chk("trip1_in", IN, 4'b0000);
        chk("trip1_retry", retry_count, 2'd1);
        chk("trip1_lock", lockout, 1'b0);
        step(19);
        chk("cool_last_st", state, 2'd2);
        chk("cool_last_in", IN, 4'b0000);
        step(1);
        chk("cool_exit_st", state, 2'd0);
        chk("cool_exit_in", IN, 4'b0000);
        step(1);
        chk("cool_resume_in", IN, 4'b0101);
        chk("cool_resume_fault", fault, 1'b0);

        strobe_with(12'd101);
        strobe_with(12'd101);
        chk("lock_st", state, 2'd3);
        chk("lock_flag", lockout, 1'b1);
        chk("lock_fault", fault, 1'b1);
        chk("lock_retry", retry_count, 2'd1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            in_cmd = 4'(i * 7 + 3);
            @(negedge clk);
            if (IN !== 4'b0000 || state !== 2'd3) bad++;
        end
        chk("lock_hold_bad", bad, 0);

        in_cmd = 4'b1001;
        reset = 1'b1;
        step(1);
        chk("lock_rst_st", state, 2'd0);
        chk("lock_rst_in", IN, 4'b0000);
        chk("lock_rst_retry", retry_count, 2'd0);
        chk("lock_rst_lock", lockout, 1'b0);

        reset = 1'b0;
        in_cmd = 4'b0101;
        current_value = 12'd50;
        step(1);
        chk("rel_in", IN, 4'b0101);
        strobe_with(12'd101);
        in_cmd = 4'b1010;
        step(1);
        chk("dtrip_dead_st", state, 2'd1);
        step(2);
        chk("dtrip_mid_st", state, 2'd1);
        chk("dtrip_mid_in", IN, 4'b0000);
        step(1);
        chk("dtrip_cool_st", state, 2'd2);
        chk("dtrip_cool_in", IN, 4'b0000);
        chk("dtrip_retry", retry_count, 2'd1);
        step(8);
        chk("dtrip_hold_in", IN, 4'b0000);
        chk("dtrip_hold_st", state, 2'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
